// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-register busy scoreboard.
// Reads are combinational, with optional same-cycle write forwarding.
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [NREAD*ADDR_WIDTH-1:0]   raddr,
  output logic [NREAD*DATA_WIDTH-1:0]   rdata,
  output logic [NREAD-1:0]              rbusy,
  input  logic                          alloc_en,
  input  logic [ADDR_WIDTH-1:0]         alloc_addr,
  output logic                          alloc_ok,
  output logic [ADDR_WIDTH:0]           busy_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

  logic alloc_zero;
  logic set_hit;
  logic clr_hit;
  logic wr_zero;

  // Read ports: zero register masks everything, then forwarding, then array.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  zero_hit;
    logic                  byp_hit;
    assign ra       = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);
    assign byp_hit  = (BYPASS != 0) && wen && (waddr == ra) && (ra != '0);
    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = zero_hit ? '0 :
                                               byp_hit  ? wdata : rf_q[ra];
    assign rbusy[i] = !(zero_hit || byp_hit) && busy_q[ra];
  end

  assign alloc_zero = (ZERO_REG != 0) && (alloc_addr == '0);
  assign alloc_ok   = alloc_zero || !busy_q[alloc_addr];
  assign set_hit    = alloc_en && alloc_ok && !alloc_zero;
  // A same-register alloc can only be accepted when busy was 0, so a
  // clear and a set never both count against the same bit.
  assign clr_hit    = wen && busy_q[waddr];
  assign wr_zero    = (ZERO_REG != 0) && (waddr == '0);
  assign busy_cnt   = cnt_q;

  always_comb begin
    busy_d = busy_q;
    if (clr_hit) busy_d[waddr] = 1'b0;
    if (set_hit) busy_d[alloc_addr] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({set_hit, clr_hit})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) rf_q[j] <= '0;
    end else if (wen && !wr_zero) begin
      rf_q[waddr] <= wdata;
    end
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: register address width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register data width.
REQ-003 SHALL have parameter NREAD, default 2: number of read ports, legal range 1..8.
REQ-004 SHALL have parameter ZERO_REG, default 1: 1 = register 0 is hardwired to zero.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = a same-cycle write is forwarded to the read ports.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all state updates occur on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port wen, input, 1 bit: write enable.
REQ-009 SHALL have port waddr, input, ADDR_WIDTH bits: write address.
REQ-010 SHALL have port wdata, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port raddr, input, NREAD*ADDR_WIDTH bits: read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 SHALL have port rdata, output, NREAD*DATA_WIDTH bits: read data, packed the same way as raddr.
REQ-013 SHALL have port rbusy, output, NREAD bits: per read port, 1 when the addressed register has a pending write.
REQ-014 SHALL have port alloc_en, input, 1 bit: request to reserve the destination register alloc_addr.
REQ-015 SHALL have port alloc_addr, input, ADDR_WIDTH bits: register to reserve.
REQ-016 SHALL have port alloc_ok, output, 1 bit: combinational; 1 when an alloc presented this cycle will be accepted.
REQ-017 SHALL have port busy_cnt, output, ADDR_WIDTH+1 bits: number of registers currently marked busy.

Function
REQ-018 SHALL implement reads as combinational: rdata port i = rf[raddr i], with no clock latency.
REQ-019 SHALL return 0 on rdata and 0 on rbusy for address 0 when ZERO_REG=1, whatever was written to it.
REQ-020 SHALL, on a clock edge with wen=1 and rst=0, write wdata into rf[waddr]; a write to address 0 is discarded when ZERO_REG=1.
REQ-021 SHALL, when BYPASS=1 and wen=1 with waddr equal to a read port's nonzero address, drive wdata on that port's rdata and 0 on its rbusy in the same cycle.
REQ-022 SHALL, when BYPASS=0, drive the pre-write register value on rdata during the write cycle; the new value appears on the next cycle.
REQ-023 SHALL keep one registered busy bit per register, and SHALL drive rbusy[i] = busy[raddr i] except where REQ-019 or REQ-021 apply.
REQ-024 SHALL drive alloc_ok = 1 exactly when alloc_addr is not busy, or is address 0 with ZERO_REG=1.
REQ-025 SHALL, on an edge with alloc_en=1 and alloc_ok=1, set busy[alloc_addr]; address 0 with ZERO_REG=1 is accepted but never marked busy.
REQ-026 SHALL ignore an alloc with alloc_ok=0: no state change; the requester retries.
REQ-027 SHALL, on an edge with wen=1, clear busy[waddr]; writing a register that is not busy is legal and leaves busy at 0.
REQ-028 SHALL, when alloc and write target the same busy register on the same edge, evaluate alloc_ok against the pre-edge busy bit (0, rejected), perform the write, and clear busy.
REQ-029 SHALL, when alloc and write target the same non-busy register on the same edge, perform the write and leave busy set (the alloc wins).
REQ-030 SHALL maintain busy_cnt as a registered count: +1 per accepted alloc that sets a bit, -1 per write that clears a set bit, net 0 when both occur on different registers; the count never wraps (maximum 2**ADDR_WIDTH).

Reset
REQ-031 SHALL, on an edge with rst=1, clear every register to 0, every busy bit to 0, and busy_cnt to 0, ignoring wen and alloc_en on that edge.
REQ-032 SHALL drive, on the cycle after reset, rdata = 0 on all ports, rbusy = 0, busy_cnt = 0, and alloc_ok = 1.
REQ-033 SHALL discard a pending reservation if rst is asserted mid-operation; a later write to that register is treated as a write to a non-busy register.

Verification
REQ-034 SHALL cover write then read: write r5=0xDEADBEEF; next cycle port 1 raddr=5 -> rdata=0xDEADBEEF, rbusy=0.
REQ-035 SHALL cover the zero register: write r0=0x1234 with ZERO_REG=1; read r0 -> 0; alloc r0 -> alloc_ok=1, busy_cnt unchanged.
REQ-036 SHALL cover bypass: with BYPASS=1, wen=1, waddr=7, wdata=0x55 while raddr0=7 -> rdata0=0x55 in the same cycle; with BYPASS=0 -> old value.
REQ-037 SHALL cover the scoreboard: alloc r3 -> busy_cnt=1, rbusy=1 on reading r3; second alloc r3 -> alloc_ok=0; write r3 -> busy_cnt=0, alloc_ok=1.
REQ-038 SHALL cover simultaneous events: with busy r4, alloc r4 plus write r4 -> rejected, busy_cnt decremented by 1; with r6 not busy, alloc r6 plus write r6 -> r6 updated, still busy.
REQ-039 SHALL cover reset mid-operation: allocate r1, r2 and write r9=0xAA, assert rst for 1 cycle -> all rdata=0, busy_cnt=0, alloc_ok=1.
